// File: rtl/i2c_scl_gen_if.sv
// i2c_scl_gen_if: controller-side bundle for the I2C SCL generator
// Ports (seen from the generator, slave modport):
//   i_en            run SCL; 0 finishes the current cycle and parks high
//   i_mode          00=100k 01=400k 10=1M 11=custom (i_div)
//   i_div           custom half-period in clk cycles
//   i_scl           SCL pad readback, asynchronous
//   o_scl           1 = release SCL, 0 = drive low
//   o_*_tick        single-cycle phase pulses (fall, mid-low, rise, mid-high)
//   o_busy          generator not idle
//   o_stretching    target is holding SCL low past the nominal rise delay
//   o_timeout       sticky stretch-timeout flag
interface i2c_scl_gen_if #(
    parameter int CNT_W = 12
);
    logic             i_en;
    logic [1:0]       i_mode;
    logic [CNT_W-1:0] i_div;
    logic             i_scl;
    logic             o_scl;
    logic             o_fall_tick;
    logic             o_mid_low_tick;
    logic             o_rise_tick;
    logic             o_mid_high_tick;
    logic             o_busy;
    logic             o_stretching;
    logic             o_timeout;
    modport slave (
        input  i_en, i_mode, i_div, i_scl,
        output o_scl, o_fall_tick, o_mid_low_tick, o_rise_tick, o_mid_high_tick,
               o_busy, o_stretching, o_timeout
    );
    modport master (
        output i_en, i_mode, i_div, i_scl,
        input  o_scl, o_fall_tick, o_mid_low_tick, o_rise_tick, o_mid_high_tick,
               o_busy, o_stretching, o_timeout
    );
endinterface

// File: rtl/i2c_scl_gen.sv
// i2c_scl_gen: run-time selectable I2C SCL generator with stretch detection and phase ticks
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    i2c_scl_gen_if.slave (enable/mode/divider in, SCL drive, ticks and status out)
module i2c_scl_gen #(
    parameter int CLK_HZ      = 50_000_000,
    parameter int CNT_W       = 12,
    parameter int STRETCH_MAX = 4095
) (
    input logic          clk,
    input logic          rst_n,
    i2c_scl_gen_if.slave bus
);
    localparam logic [CNT_W-1:0] HALF_100K = CNT_W'(CLK_HZ / 200_000);
    localparam logic [CNT_W-1:0] HALF_400K = CNT_W'(CLK_HZ / 800_000);
    localparam logic [CNT_W-1:0] HALF_1M   = CNT_W'(CLK_HZ / 2_000_000);
    localparam logic [CNT_W-1:0] HALF_MIN  = CNT_W'(4);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] STR_LAST  = CNT_W'(STRETCH_MAX - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOW, S_HWAIT, S_HIGH} state_t;

    state_t           r_state, w_state_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx;
    logic [CNT_W-1:0] r_scnt, w_scnt_nx;
    logic [CNT_W-1:0] r_half, w_half_nx;
    logic             r_timeout, w_timeout_nx;
    logic [1:0]       r_sync;
    logic             w_scl_s;
    logic [CNT_W-1:0] w_half_sel;
    logic [CNT_W-1:0] w_qtr;

    assign w_scl_s    = r_sync[1];
    assign w_qtr      = r_half >> 1;
    assign w_half_sel = bus.i_mode == 2'b00 ? HALF_100K :
                        bus.i_mode == 2'b01 ? HALF_400K :
                        bus.i_mode == 2'b10 ? HALF_1M   :
                        bus.i_div < HALF_MIN ? HALF_MIN : bus.i_div;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_scnt    <= '0;
            r_half    <= '0;
            r_timeout <= 1'b0;
            r_sync    <= 2'b11;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_scnt    <= w_scnt_nx;
            r_half    <= w_half_nx;
            r_timeout <= w_timeout_nx;
            r_sync    <= {r_sync[0], bus.i_scl};
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt;
        w_scnt_nx    = r_scnt;
        w_half_nx    = r_half;
        w_timeout_nx = r_timeout;
        case (r_state)
            S_IDLE: begin
                w_cnt_nx  = '0;
                w_scnt_nx = '0;
                if (bus.i_en) begin
                    w_state_nx   = S_LOW;
                    w_half_nx    = w_half_sel;
                    w_timeout_nx = 1'b0;
                end
            end
            S_LOW: begin
                w_cnt_nx = r_cnt + ONE;
                if (r_cnt == r_half - ONE) begin
                    w_state_nx = S_HWAIT;
                    w_cnt_nx   = '0;
                    w_scnt_nx  = '0;
                end
            end
            S_HWAIT: begin
                // Pad release is only trusted once it has crossed the synchronizer,
                // so even an unstretched bus spends 3 cycles here.
                w_scnt_nx = r_scnt + ONE;
                if (w_scl_s) begin
                    w_state_nx = S_HIGH;
                    w_cnt_nx   = '0;
                end else if (r_scnt == STR_LAST) begin
                    w_state_nx   = S_IDLE;
                    w_timeout_nx = 1'b1;
                end
            end
            default: begin
                w_cnt_nx = r_cnt + ONE;
                if (r_cnt == r_half - ONE) begin
                    w_state_nx = bus.i_en ? S_LOW : S_IDLE;
                    w_cnt_nx   = '0;
                end
            end
        endcase
    end

    // Ticks decode from registered state/count; they live in disjoint state/count
    // slots (QTR >= 2 because HALF >= 4), so at most one fires per cycle.
    assign bus.o_scl           = r_state != S_LOW;
    assign bus.o_fall_tick     = r_state == S_LOW  && r_cnt == '0;
    assign bus.o_mid_low_tick  = r_state == S_LOW  && r_cnt == w_qtr;
    assign bus.o_rise_tick     = r_state == S_HIGH && r_cnt == '0;
    assign bus.o_mid_high_tick = r_state == S_HIGH && r_cnt == w_qtr;
    assign bus.o_busy          = r_state != S_IDLE;
    assign bus.o_stretching    = r_state == S_HWAIT && r_scnt >= CNT_W'(3);
    assign bus.o_timeout       = r_timeout;
endmodule

// File: tb/tb_i2c_scl_gen.sv
// tb_i2c_scl_gen: table-driven and scoreboard checks of SCL timing, stretch, timeout and reset
module tb_i2c_scl_gen;
    localparam int CNT_W = 12;

    typedef struct {
        logic [1:0] mode;
        int         div;
        logic [1:0] mode2;
        int         div2;
        int         periods;
        int         half;
    } vec_t;

    typedef struct {
        int kind;
        int val;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic hold = 1'b0;
    bit   mon_on = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   low_len, high_len, since_fall, since_rise;
    bit   seen_low;
    exp_t sb[$];
    string kname[4] = '{"low_len", "high_len", "mid_low_ofs", "mid_high_ofs"};

    i2c_scl_gen_if #(.CNT_W(CNT_W)) b ();
    i2c_scl_gen_if #(.CNT_W(CNT_W)) b2 ();

    assign b.i_scl  = b.o_scl & ~hold;
    assign b2.i_scl = 1'b0;

    i2c_scl_gen #(.CLK_HZ(50_000_000), .CNT_W(CNT_W), .STRETCH_MAX(4095)) dut (
        .clk(clk), .rst_n(rst_n), .bus(b)
    );
    i2c_scl_gen #(.CLK_HZ(50_000_000), .CNT_W(CNT_W), .STRETCH_MAX(100)) dut_to (
        .clk(clk), .rst_n(rst_n), .bus(b2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d want %0d..%0d", nm, act, lo, hi);
        end
    endtask

    task automatic emit(input int k, input int v);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_%s: got %0d want no event", kname[k], v);
        end else begin
            e = sb.pop_front();
            if (k != e.kind) chk("event_kind", k, e.kind);
            else chk(kname[k], v, e.val);
        end
    endtask

    function automatic bit hit(input int w);
        case (w)
            0: hit = b.o_rise_tick;
            1: hit = b.o_fall_tick;
            2: hit = !b.o_busy;
            3: hit = b.o_scl;
            4: hit = b.o_stretching;
            5: hit = b2.o_fall_tick;
            6: hit = b2.o_scl;
            7: hit = !b2.o_busy;
            default: hit = 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int w, input int budget, output int n);
        bit done;
        n = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (hit(w)) done = 1'b1;
            else begin
                n++;
                if (n >= budget) begin
                    total++;
                    bad++;
                    $display("FAIL wait_%0d: timed out after %0d cycles, want event", w, budget);
                    done = 1'b1;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n || !mon_on) begin
            low_len  = 0;
            high_len = 0;
            seen_low = 1'b0;
        end else begin
            since_fall = b.o_fall_tick ? 0 : since_fall + 1;
            since_rise = b.o_rise_tick ? 0 : since_rise + 1;
            if (b.o_mid_low_tick) emit(2, since_fall);
            if (b.o_mid_high_tick) emit(3, since_rise);
            if (!b.o_scl) begin
                if (high_len > 0) emit(1, high_len);
                high_len = 0;
                low_len++;
                seen_low = 1'b1;
            end else begin
                if (low_len > 0) emit(0, low_len);
                low_len = 0;
                if (seen_low && b.o_busy) high_len++;
            end
            if (!b.o_busy) begin
                seen_low = 1'b0;
                high_len = 0;
            end
        end
    end

    task automatic run_vec(input vec_t v);
        int c;
        b.i_mode = v.mode;
        b.i_div  = CNT_W'(v.div);
        for (int i = 0; i < v.periods; i++) begin
            sb.push_back('{2, v.half >> 1});
            sb.push_back('{0, v.half});
            sb.push_back('{3, v.half >> 1});
            if (i < v.periods - 1) sb.push_back('{1, v.half + 3});
        end
        mon_on = 1'b1;
        b.i_en = 1'b1;
        for (int i = 0; i < v.periods; i++) begin
            wait_for(0, 2000, c);
            if (i == 0) begin
                b.i_mode = v.mode2;
                b.i_div  = CNT_W'(v.div2);
            end
        end
        b.i_en = 1'b0;
        wait_for(2, 2000, c);
        repeat (4) @(negedge clk);
        chk("vec_drain", sb.size(), 0);
        sb.delete();
        chk("vec_park_scl", int'(b.o_scl), 1);
        mon_on = 1'b0;
    endtask

    initial begin
        vec_t vt[8];
        int   c, n;
        vt[0] = '{2'b00, 0,  2'b00, 0,  2, 250};
        vt[1] = '{2'b01, 0,  2'b10, 0,  3, 62};
        vt[2] = '{2'b10, 0,  2'b10, 0,  3, 25};
        vt[3] = '{2'b11, 2,  2'b11, 2,  2, 4};
        vt[4] = '{2'b11, 0,  2'b11, 0,  2, 4};
        vt[5] = '{2'b11, 4,  2'b00, 0,  2, 4};
        vt[6] = '{2'b11, 5,  2'b11, 5,  2, 5};
        vt[7] = '{2'b11, 10, 2'b01, 3,  3, 10};
        b.i_en = 1'b0; b.i_mode = 2'b00; b.i_div = '0;
        b2.i_en = 1'b0; b2.i_mode = 2'b10; b2.i_div = '0;

        // reset and idle
        repeat (5) @(negedge clk);
        chk("rst_scl", int'(b.o_scl), 1);
        chk("rst_busy", int'(b.o_busy), 0);
        chk("rst_ticks", int'({b.o_fall_tick, b.o_mid_low_tick, b.o_rise_tick, b.o_mid_high_tick}), 0);
        chk("rst_status", int'({b.o_stretching, b.o_timeout}), 0);
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (b.o_scl && !b.o_busy && !b.o_stretching && !b.o_timeout &&
                !(b.o_fall_tick | b.o_mid_low_tick | b.o_rise_tick | b.o_mid_high_tick)) n++;
        end
        chk("idle_quiet_cycles", n, 1000);

        // rate table in loopback
        for (int i = 0; i < 8; i++) run_vec(vt[i]);

        // en dropped in the first LOW cycle with clamped custom divider
        b.i_mode = 2'b11; b.i_div = CNT_W'(2);
        sb.push_back('{2, 2}); sb.push_back('{0, 4}); sb.push_back('{3, 2});
        mon_on = 1'b1;
        b.i_en = 1'b1;
        wait_for(1, 100, c);
        b.i_en = 1'b0;
        wait_for(2, 100, c);
        chk("drop_busy_cycles", c + 1, 11);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (b.o_scl && !b.o_busy) n++;
        end
        chk("drop_parked_cycles", n, 20);
        chk("drop_drain", sb.size(), 0);
        sb.delete();
        mon_on = 1'b0;

        // asynchronous reset mid-LOW
        b.i_div = CNT_W'(10);
        b.i_en = 1'b1;
        wait_for(1, 100, c);
        repeat (3) @(negedge clk);
        chk("pre_rst_scl_low", int'(b.o_scl), 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_scl", int'(b.o_scl), 1);
        chk("midrst_busy", int'(b.o_busy), 0);
        chk("midrst_ticks", int'({b.o_fall_tick, b.o_mid_low_tick, b.o_rise_tick, b.o_mid_high_tick}), 0);
        b.i_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // target stretches SCL ~400 cycles at 100k
        b.i_mode = 2'b00;
        hold = 1'b1;
        b.i_en = 1'b1;
        wait_for(1, 100, c);
        b.i_en = 1'b0;
        wait_for(3, 1000, c);
        @(negedge clk); chk("stretch_hw1", int'(b.o_stretching), 0);
        @(negedge clk); chk("stretch_hw2", int'(b.o_stretching), 0);
        @(negedge clk); chk("stretch_hw3", int'(b.o_stretching), 1);
        repeat (396) @(negedge clk);
        chk("stretch_held_busy", int'(b.o_busy & b.o_scl & b.o_stretching), 1);
        hold = 1'b0;
        wait_for(0, 20, c);
        chk_rng("stretch_rise_delay", c + 1, 2, 3);
        wait_for(2, 1000, c);
        chk("stretch_high_len", c + 1, 250);
        chk("stretch_timeout", int'(b.o_timeout), 0);

        // SCL stuck low on the STRETCH_MAX=100 instance
        b2.i_en = 1'b1;
        wait_for(5, 100, c);
        b2.i_en = 1'b0;
        wait_for(6, 100, c);
        wait_for(7, 300, c);
        chk("to_hwait_cycles", c + 1, 100);
        chk("to_flag", int'(b2.o_timeout), 1);
        chk("to_scl", int'(b2.o_scl), 1);
        chk("to_no_rise", int'(b2.o_rise_tick), 0);
        repeat (5) @(negedge clk);
        chk("to_sticky", int'(b2.o_timeout), 1);
        b2.i_en = 1'b1;
        @(negedge clk);
        b2.i_en = 1'b0;
        chk("to_restart_clear", int'(b2.o_timeout), 0);
        chk("to_restart_fall", int'(b2.o_fall_tick), 1);
        wait_for(7, 400, c);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/i2c_scl_gen.md
Name: i2c_scl_gen

Overview:
Parametrised I2C SCL generator for the FMC424 I2C controller. It replaces the fixed 100 kHz divider with these features:
- run-time selectable bus speed (100k / 400k / 1M / custom divider);
- open-drain SCL drive with clock-stretching detection and a stretch timeout;
- single-cycle phase ticks (fall, mid-low, rise, mid-high) that the byte/bit FSM uses to change SDA in mid-low and sample SDA in mid-high.

Sits between the controller FSM and the SCL IOBUF.

Parameters:
CLK_HZ, 50_000_000, input clock frequency in Hz; preset half-periods derive from it.
CNT_W, 12, width of half-period and stretch counters.
STRETCH_MAX, 4095, max CLK cycles SCL may be held low by a target before timeout (must fit CNT_W).

Ports:
CLK  in  1  system clock, all logic on rising edge.
rst  in  1  asynchronous active-low reset.
en  in  1  1 = run SCL; 0 = finish current cycle then park high.
mode  in  2  00=100k, 01=400k, 10=1M, 11=custom (div_i).
div_i  in  CNT_W  custom half-period in CLK cycles (mode 11).
scl_in  in  1  SCL pad readback (IOBUF "O"), asynchronous.
scl_o  out  1  1 = release SCL (IOBUF T=1), 0 = drive low.
fall_tick  out  1  1-cycle pulse, cycle SCL is driven low.
mid_low_tick  out  1  1-cycle pulse, midpoint of low phase (SDA change point).
rise_tick  out  1  1-cycle pulse, cycle synced SCL is seen high.
mid_high_tick  out  1  1-cycle pulse, midpoint of high phase (SDA sample point).
busy  out  1  1 whenever state != IDLE.
stretching  out  1  1 while in HIGH_WAIT beyond the first 3 cycles.
timeout  out  1  sticky stretch-timeout flag.

Behaviour:
- Reset: state IDLE, scl_o=1, all ticks 0, busy=0, stretching=0, timeout=0, counters 0, sync flops 1.
- scl_in passes through a 2-flop synchronizer (scl_s); only scl_s is used.
- Half-period HALF: 100k = CLK_HZ/200_000 (250); 400k = CLK_HZ/800_000 (62); 1M = CLK_HZ/2_000_000 (25); custom = div_i, with values <4 clamped to 4. Integer division rounds down.
- HALF is latched on the IDLE->LOW transition only. Mode/div_i changes mid-run have no effect until the next start.
- QTR = HALF>>1.
- IDLE: scl_o=1, cnt=0. If en=1, go to LOW; fall_tick is asserted in the cycle scl_o first reads 0.
- LOW: scl_o=0, cnt increments 0..HALF-1.
  - mid_low_tick when cnt==QTR.
  - At cnt==HALF-1: go to HIGH_WAIT, cnt=0.
- HIGH_WAIT: scl_o=1, stretch counter increments.
  - If scl_s==1: go to HIGH, rise_tick in the first HIGH cycle.
  - If stretch counter reaches STRETCH_MAX: go to IDLE, set timeout=1, no rise_tick.
  - stretching=1 once the stretch counter >=3.
  - With no target stretching (pad follows scl_o), HIGH_WAIT lasts exactly 3 cycles.
- HIGH: scl_o=1, cnt 0..HALF-1.
  - mid_high_tick when cnt==QTR.
  - At cnt==HALF-1: if en=1, go to LOW (fall_tick); else go to IDLE.
- en deassert in LOW/HIGH_WAIT/HIGH: the current cycle completes through the end of HIGH, then IDLE. SCL always parks released/high, so the controller can issue STOP.
- Nominal SCL period = 2*HALF+3 cycles; 100k at 50 MHz = 503 cycles.
- timeout clears on the IDLE->LOW transition (next start); it does not block restart.
- Mid-run reset: immediate IDLE, scl_o=1, ticks 0.
- Tick exclusivity: at most one tick is high in any cycle.
- Ticks are never asserted in IDLE.

Test Plan:
- Reset/idle: rst low 5 cycles, en=0 -> scl_o=1, busy=0, all ticks 0 for 1000 cycles.
- 100k loopback (scl_in=scl_o), en=1, mode=00 ->
  - low phase 250 cycles, high phase 253 cycles, rise-to-rise 503;
  - mid_low_tick 125 cycles after fall_tick;
  - mid_high_tick 125 cycles after rise_tick.
- Mode switch: run 400k 3 periods (62 low / 65 high), drop en, set mode=10, re-enable ->
  - old rate until IDLE;
  - then 25 low / 28 high.
- Stretch: target holds scl_in low 400 cycles after release ->
  - stretching=1 from HIGH_WAIT cycle 3;
  - rise_tick 2-3 cycles after scl_in rises;
  - HIGH still 250 cycles;
  - timeout=0.
- Timeout: STRETCH_MAX=100, scl_in stuck low ->
  - IDLE after 100 HIGH_WAIT cycles, timeout=1, scl_o=1;
  - next en start clears timeout.
- Custom/clamp: mode=11, div_i=2 -> HALF=4 (low 4, high 7); en dropped mid-LOW -> cycle finishes, busy falls after HIGH, scl_o stays 1.
